mem32_port_arbiter: RTL and testbench
=====================================

Name: mem32_port_arbiter

Overview:
- Shares one single-port mem32 instance between the instruction-fetch requester (i-port, read-only) and the data-memory requester (d-port, read/write) of the pipelined MIPS core.
- Arbitrates between the two, sequences each access through a 3-state FSM and registers every memory-side control signal.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the IF/MEM pipeline stages and the mem32 block.

Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the i-port is forced to win

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- i_req  input  1  fetch request; held with i_addr until i_ack
- i_addr  input  AW  fetch address
- i_ack  output  1  one-cycle completion pulse for the i-port
- i_rdata  output  DW  fetch data, valid while i_ack=1
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  write data
- d_ack  output  1  one-cycle completion pulse for the d-port
- d_rdata  output  DW  read data, valid while d_ack=1 and the access was a read
- err  output  1  pulses with an ack when the acknowledged access was misaligned
- busy  output  1  1 whenever the FSM is not in IDLE
- mem_read  output  1  to mem32 mem_read
- mem_write  output  1  to mem32 mem_write
- mem_addr  output  AW  to mem32 address
- mem_wdata  output  DW  to mem32 data_in
- mem_rdata  input  DW  from mem32 data_out; valid the cycle after mem_read

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0, FSM in IDLE, starvation counter 0, latched owner/addr/wdata/we 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Neither request: stay in IDLE.
  - Any request: pick a winner; latch owner, addr, wdata and we (we forced 0 for the i-port); go to ACCESS.
- Arbitration:
  - d-port has fixed priority over the i-port.
  - Exception: when starve_cnt == STARVE_LIMIT and i_req=1, the i-port wins.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments in an IDLE cycle where i_req=1 and the d-port wins.
  - Clears when the i-port wins.
  - Holds otherwise.
- ACCESS:
  - Registered outputs for exactly one cycle: mem_read = ~we, mem_write = we, mem_addr = latched addr, mem_wdata = latched wdata.
  - Misaligned address (addr[1:0] != 0): mem_read and mem_write stay 0; misalign flag latched.
  - Next state is RESP.
- RESP:
  - mem_read and mem_write return to 0.
  - Owner's ack = 1 for one cycle.
  - Owner's rdata = mem_rdata on an aligned read; 0 on a write or misaligned access.
  - err = misalign flag.
  - Next state is IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge T; memory strobe visible after T+1; ack visible after T+2.
  - Throughput is 1 access per 3 cycles.
- Non-owner outputs: ack and err for the non-owning port are always 0. rdata holds its last acknowledged value.
- Memory-side idle values: mem_addr and mem_wdata hold their last value outside ACCESS; only the strobes define validity.
- Request dropped before ack (protocol violation): the transaction still completes and acks. Bench checker flags the violation.
- Request changes during ACCESS/RESP: ignored; the latched values are used.
- Simultaneous requests: handled per the arbitration rule. The loser stays pending and is arbitrated at the next IDLE.
- Reset mid-operation: rst_n=0 in ACCESS or RESP forces IDLE with all outputs 0 at that edge. The in-flight access is abandoned with no ack, and the memory strobe drops immediately.
- busy: registered, equals (state != IDLE).

Test Plan:
- Reset, then d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_write=1 with mem_addr=0x10 and mem_wdata=0xDEADBEEF one cycle later, then d_ack=1 and err=0 the next cycle. Follow with a d-port read of 0x10 -> d_rdata=0xDEADBEEF with d_ack.
- i_req=1, i_addr=0x40 alone with memory preloaded with 0x8C220004 -> mem_read=1 and mem_addr=0x40, then i_ack=1 and i_rdata=0x8C220004. d_ack stays 0 throughout.
- i_req and d_req held high continuously (STARVE_LIMIT=4) -> grant order d,d,d,d,i,d,d,d,d,i. Each ack is 3 cycles apart. starve_cnt returns to 0 after each i grant.
- d_req read at d_addr=0x13 -> no mem_read/mem_write pulse; d_ack=1, err=1, d_rdata=0 two cycles after the request is sampled.
- Start a d write to 0x20, assert rst_n=0 in the ACCESS cycle -> mem_write=0 after that edge, no d_ack, busy=0. A subsequent read of 0x20 returns the pre-write contents.
- Raise i_req while a d access is in RESP -> i access starts at the next IDLE; i_ack arrives exactly 3 cycles after that IDLE edge.

Source files
------------

// File: rtl/mem32_port_arbiter.sv
// mem32 port arbiter: one single-port mem32 shared by the fetch and data ports.
// d-port has priority; the i-port is forced through after STARVE_LIMIT losses.
module mem32_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          err,
   output logic          busy,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state;
   logic [CW-1:0] starve_cnt;
   logic          own_d;
   logic          lat_we;
   logic          mis;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          i_win;
   logic          aligned;
   logic [DW-1:0] rd_val;

   // i-port wins when alone or once it has lost too many times in a row
   assign i_win   = i_req && (!d_req || starve_cnt == LIMIT);
   assign aligned = (lat_addr[1:0] == 2'b00);
   assign rd_val  = (!lat_we && !mis) ? mem_rdata : '0;

   // sequencer: arbitrate in IDLE, strobe memory in ACCESS, acknowledge in RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         own_d      <= 1'b0;
         lat_we     <= 1'b0;
         mis        <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         i_ack      <= 1'b0;
         i_rdata    <= '0;
         d_ack      <= 1'b0;
         d_rdata    <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  own_d     <= !i_win;
                  lat_we    <= i_win ? 1'b0 : d_we;
                  lat_addr  <= i_win ? i_addr : d_addr;
                  lat_wdata <= i_win ? '0 : d_wdata;
                  if (i_win)
                     starve_cnt <= '0;
                  else if (i_req && starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 1'b1;
                  state <= ACCESS;
                  busy  <= 1'b1;
               end
            end
            ACCESS: begin
               mem_read  <= !lat_we && aligned;
               mem_write <= lat_we && aligned;
               mem_addr  <= lat_addr;
               mem_wdata <= lat_wdata;
               mis       <= !aligned;
               state     <= RESP;
            end
            RESP: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               if (own_d) begin
                  d_ack   <= 1'b1;
                  d_rdata <= rd_val;
               end else begin
                  i_ack   <= 1'b1;
                  i_rdata <= rd_val;
               end
               err   <= mis;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem32_port_arbiter.sv
// Bench for mem32_port_arbiter: directed scenarios plus random two-port traffic,
// with per-port expected-response queues drained by a monitor.
module tb_mem32_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_ack, d_ack, err, busy;
   logic [31:0] i_rdata, d_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem32_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory device: combinational read, write on the clock edge
   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

   // reference model state
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic [31:0] ref_mem [0:255];
   exp_t        iq[$];
   exp_t        dq[$];
   byte         order_q[$];
   logic [31:0] last_i, last_d;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic we, input logic [31:0] a,
                                  input logic [31:0] wd);
      exp_t e;
      logic mis;
      mis     = (a[1:0] != 2'b00);
      e.we    = we;
      e.addr  = a;
      e.wdata = wd;
      e.err   = mis;
      e.rdata = (!we && !mis) ? ref_mem[a[9:2]] : 32'h0;
      if (we && !mis) ref_mem[a[9:2]] = wd;
      return e;
   endfunction

   task automatic issue_d(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
      dq.push_back(model(we, a, wd));
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
   endtask

   task automatic issue_i(input logic [31:0] a);
      iq.push_back(model(1'b0, a, 32'h0));
      i_addr = a; i_req = 1'b1;
   endtask

   task automatic wait_ack(input bit is_d, output int at);
      at = -1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (is_d ? d_ack : i_ack) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout port_d=%0d", is_d);
      end
   endtask

   // monitor: strobe capture and scoreboard drain
   logic        seen_st, st_rd, st_wr;
   logic [31:0] st_addr, st_wdata;
   int          st_cyc;

   task automatic take(input bit is_d);
      exp_t        e;
      logic [31:0] rd, oth, oth_last;
      bit          al;
      if ((is_d && dq.size() == 0) || (!is_d && iq.size() == 0)) begin
         checks++; errors++;
         $display("FAIL unexpected_ack port_d=%0d got 1 expected 0", is_d);
         return;
      end
      if (is_d) begin
         e = dq.pop_front(); rd = d_rdata; oth = i_rdata; oth_last = last_i;
      end else begin
         e = iq.pop_front(); rd = i_rdata; oth = d_rdata; oth_last = last_d;
      end
      al = (e.addr[1:0] == 2'b00);
      check("rdata", rd, e.rdata);
      check("err", 32'(err), 32'(e.err));
      check("strobe_seen", 32'(seen_st), 32'(al));
      if (al && seen_st) begin
         check("strobe_wr", 32'(st_wr), 32'(e.we));
         check("strobe_rd", 32'(st_rd), 32'(!e.we));
         check("mem_addr", st_addr, e.addr);
         if (e.we) check("mem_wdata", st_wdata, e.wdata);
         check("ack_after_strobe", 32'(cyc - st_cyc), 32'd1);
      end
      check("other_rdata_held", oth, oth_last);
      if (is_d) last_d = e.rdata;
      else last_i = e.rdata;
      seen_st = 1'b0;
      order_q.push_back(is_d ? "d" : "i");
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         seen_st = 1'b0;
         last_i  = 32'h0;
         last_d  = 32'h0;
      end else begin
         if (mem_read || mem_write) begin
            check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
            seen_st  = 1'b1;
            st_rd    = mem_read;
            st_wr    = mem_write;
            st_addr  = mem_addr;
            st_wdata = mem_wdata;
            st_cyc   = cyc;
         end
         if (err) check("err_with_ack", 32'(i_ack | d_ack), 32'd1);
         if (i_ack && d_ack) check("one_ack", 32'd2, 32'd1);
         if (d_ack) take(1'b1);
         if (i_ack) take(1'b0);
      end
   end

   function automatic logic [31:0] rand_addr(input logic [31:0] base);
      logic [31:0] a;
      a = base + (32'($urandom_range(0, 127)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t0, t1, t2;
      int          acks[$];
      string       pat;
      int          n;
      logic [31:0] a, w;

      pat = "ddddiddddi";
      for (int k = 0; k < 256; k++) begin
         w          = $urandom;
         mem[k]     = w;
         ref_mem[k] = w;
      end
      mem[16]     = 32'h8C220004;
      ref_mem[16] = 32'h8C220004;

      rst_n = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_i_ack", 32'(i_ack), 0);
      check("rst_d_ack", 32'(d_ack), 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_read", 32'(mem_read), 0);
      check("rst_mem_write", 32'(mem_write), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // write then read back on the d-port
      t0 = cyc;
      issue_d(1'b1, 32'h10, 32'hDEADBEEF);
      wait_ack(1'b1, t1);
      d_req = 1'b0;
      check("wr_latency", 32'(t1 - t0), 32'd3);
      t0 = cyc;
      issue_d(1'b0, 32'h10, 32'h0);
      wait_ack(1'b1, t1);
      d_req = 1'b0;
      check("rd_latency", 32'(t1 - t0), 32'd3);
      check("rd_back", d_rdata, 32'hDEADBEEF);

      // lone fetch from preloaded word
      issue_i(32'h40);
      wait_ack(1'b0, t1);
      i_req = 1'b0;
      check("fetch_data", i_rdata, 32'h8C220004);

      // misaligned data read
      t0 = cyc;
      issue_d(1'b0, 32'h13, 32'h0);
      wait_ack(1'b1, t1);
      d_req = 1'b0;
      check("mis_latency", 32'(t1 - t0), 32'd3);
      check("mis_err", 32'(err), 32'd1);

      // continuous contention: d wins four times, then i is forced through
      repeat (2) @(posedge clk);
      #1;
      order_q.delete();
      for (int k = 0; k < 10; k++) begin
         if (pat[k] == "d") dq.push_back(model(1'b0, 32'h204, 32'h0));
         else iq.push_back(model(1'b0, 32'h44, 32'h0));
      end
      d_we = 1'b0; d_addr = 32'h204; i_addr = 32'h44;
      d_req = 1'b1; i_req = 1'b1;
      n = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (d_ack || i_ack) begin
            acks.push_back(cyc);
            n++;
            if (n == 10) break;
         end
      end
      d_req = 1'b0; i_req = 1'b0;
      repeat (2) @(negedge clk);
      check("starve_ack_count", 32'(acks.size()), 32'd10);
      for (int k = 1; k < acks.size(); k++)
         check("starve_spacing", 32'(acks[k] - acks[k-1]), 32'd3);
      check("starve_order_len", 32'(order_q.size()), 32'd10);
      for (int k = 0; k < 10 && k < order_q.size(); k++)
         check("starve_order", 32'(order_q[k]), 32'(pat[k]));
      @(posedge clk); #1;

      // reset in the ACCESS cycle of a write abandons it
      d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
      @(posedge clk); #1;
      check("access_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_mem_write", 32'(mem_write), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_d_ack", 32'(d_ack), 0);
      d_req = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      issue_d(1'b0, 32'h20, 32'h0);
      wait_ack(1'b1, t1);
      d_req = 1'b0;

      // fetch raised while a data access is in RESP
      issue_d(1'b0, 32'h208, 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      issue_i(32'h48);
      wait_ack(1'b1, t1);
      d_req = 1'b0;
      wait_ack(1'b0, t2);
      i_req = 1'b0;
      check("late_fetch_gap", 32'(t2 - t1), 32'd3);

      // random concurrent traffic, i in the low region, d in the high region
      fork
         begin
            int at;
            for (int k = 0; k < 80; k++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               issue_i(rand_addr(32'h0));
               wait_ack(1'b0, at);
               i_req  = 1'b0;
               i_addr = $urandom;
            end
         end
         begin
            int at;
            for (int k = 0; k < 80; k++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               a = rand_addr(32'h200);
               issue_d(1'($urandom_range(0, 1)), a, $urandom);
               wait_ack(1'b1, at);
               d_req   = 1'b0;
               d_wdata = $urandom;
            end
         end
      join

      repeat (5) @(posedge clk);
      check("iq_drained", 32'(iq.size()), 0);
      check("dq_drained", 32'(dq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
